// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: byte/half/word accesses to a 32-bit word memory.
// Sub-word stores are done as a read-modify-write of the containing word.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic        signed_q, signed_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rmw_q, rmw_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    logic        req_err;
    logic [4:0]  lane_lsb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        req_err = (req_size == 2'b11)
                | ((req_size == 2'b01) & req_addr[0])
                | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // Little-endian lane select from the latched address
    always_comb begin
        lane_lsb = {addr_q[1:0], 3'b000};
        ld_byte  = mem_rdata[lane_lsb +: 8];
        ld_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ld_ext = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = rmw_q;
        case (size_q)
            2'b00: merged[lane_lsb +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = rmw_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        signed_d = signed_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rmw_d    = rmw_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    signed_d = req_signed;
                    size_d   = req_size;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_err) begin
                        state_d = RESP;
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        valid_d = 1'b1;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                state_d = RESP;
                rdata_d = ld_ext;
                err_d   = 1'b0;
                valid_d = 1'b1;
            end
            STORE, RMW_WR: begin
                state_d = RESP;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                valid_d = 1'b1;
            end
            RMW_RD: begin
                state_d = RMW_WR;
                rmw_d   = mem_rdata;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            rmw_q    <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            signed_q <= signed_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rmw_q    <= rmw_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    // Strobes decode the state but are forced low in a reset cycle
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = valid_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_read   = !rst & ((state_q == LOAD) | (state_q == RMW_RD));
        mem_write  = !rst & ((state_q == STORE) | (state_q == RMW_WR));
        mem_addr   = {addr_q[31:2], 2'b00};
        mem_wdata  = (state_q == STORE) ? wdata_q : merged;
    end

    // write_q is latched for completeness of the request record
    logic unused_ok;
    always_comb unused_ok = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Table-driven bench for load_store_unit with a word-memory model and a
// response scoreboard checking data, error flag and latency.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic [31:0] mem [256];
    exp_t        sb [$];
    vec_t        tbl [$];

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int n_rd = 0;
    int n_wr = 0;
    int last_rd_cyc = -1;
    int last_wr_cyc = -1;
    logic [31:0] last_wr_addr = 32'h0;

    assign mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h5A5A5A5A;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_read)  n_rd <= n_rd + 1;
        if (mem_write) begin
            n_wr <= n_wr + 1;
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mem_read)  last_rd_cyc = cyc;
        if (mem_write) begin
            last_wr_cyc  = cyc;
            last_wr_addr = mem_addr;
        end
        if (mem_read && mem_write) begin
            n_bad++;
            $display("FAIL rw_overlap: read and write both high at cycle %0d",
                     cyc);
        end
        if (resp_valid) begin
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_resp: resp_valid with nothing pending at cycle %0d",
                         cyc);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] sz,
                                input logic sg, input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] exp_rdata,
                                input logic exp_err, input int lat);
        vec_t v;
        v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.lat = lat;
        return v;
    endfunction

    // Busy cycles get random junk on req_* which the unit must ignore
    task automatic issue(input vec_t v, output int t);
        int k = 0;
        t = -1;
        @(negedge clk);
        while (!req_ready && k < 30) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_write  = 1'($urandom);
            req_size   = 2'($urandom);
            req_signed = 1'($urandom);
            req_addr   = $urandom;
            req_wdata  = $urandom;
            k++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL issue_timeout: req_ready stuck at 0 for addr %h",
                     v.addr);
            req_valid = 1'b0;
            return;
        end
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_size   = v.sz;
        req_signed = v.sg;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        t = cyc;
        sb.push_back('{v.exp_rdata, v.exp_err, cyc + v.lat});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (!(sb.size() == 0 && req_ready) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses still pending",
                     sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int t, t2, rd0, wr0;
        logic [31:0] saved;
        vec_t v;

        for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        mem[4] <= 32'h8899AABB;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

        tbl.push_back(mk(0, 2'b00, 1, 32'h11, 0, 32'hFFFFFFAA, 0, 2));
        tbl.push_back(mk(0, 2'b01, 0, 32'h12, 0, 32'h00008899, 0, 2));
        tbl.push_back(mk(0, 2'b01, 1, 32'h12, 0, 32'hFFFF8899, 0, 2));
        tbl.push_back(mk(0, 2'b00, 0, 32'h10, 0, 32'h000000BB, 0, 2));
        tbl.push_back(mk(0, 2'b10, 0, 32'h10, 0, 32'h8899AABB, 0, 2));
        tbl.push_back(mk(1, 2'b00, 0, 32'h13, 32'h123456CC, 0, 0, 3));
        tbl.push_back(mk(0, 2'b10, 0, 32'h10, 0, 32'hCC99AABB, 0, 2));
        tbl.push_back(mk(1, 2'b01, 0, 32'h10, 32'hFFFF1234, 0, 0, 3));
        tbl.push_back(mk(0, 2'b01, 1, 32'h10, 0, 32'h00001234, 0, 2));
        tbl.push_back(mk(0, 2'b10, 0, 32'h16, 0, 32'h0, 1, 1));
        tbl.push_back(mk(0, 2'b11, 0, 32'h10, 0, 32'h0, 1, 1));
        tbl.push_back(mk(0, 2'b01, 1, 32'h11, 0, 32'h0, 1, 1));
        tbl.push_back(mk(1, 2'b01, 0, 32'h13, 32'hBEEF, 32'h0, 1, 1));
        tbl.push_back(mk(1, 2'b10, 0, 32'h14, 32'h01020304, 0, 0, 2));
        tbl.push_back(mk(0, 2'b00, 1, 32'h15, 0, 32'h00000003, 0, 2));
        tbl.push_back(mk(1, 2'b00, 0, 32'h16, 32'h000000FF, 0, 0, 3));
        tbl.push_back(mk(0, 2'b00, 1, 32'h16, 0, 32'hFFFFFFFF, 0, 2));
        tbl.push_back(mk(0, 2'b10, 0, 32'h14, 0, 32'h01FF0304, 0, 2));
        tbl.push_back(mk(1, 2'b01, 0, 32'h16, 32'h0000ABCD, 0, 0, 3));
        tbl.push_back(mk(0, 2'b01, 0, 32'h16, 0, 32'h0000ABCD, 0, 2));

        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            v = tbl[i];
            rd0 = n_rd;
            wr0 = n_wr;
            issue(v, t);
            drain();
            if (v.exp_err) begin
                chk("err_no_read", n_rd, rd0);
                chk("err_no_write", n_wr, wr0);
            end else if (!v.wr) begin
                chk("load_read_cycle", last_rd_cyc, t + 1);
            end else if (v.sz == 2'b10) begin
                chk("word_write_cycle", last_wr_cyc, t + 1);
                chk("word_write_addr", last_wr_addr, {v.addr[31:2], 2'b00});
            end else begin
                chk("rmw_read_cycle", last_rd_cyc, t + 1);
                chk("rmw_write_cycle", last_wr_cyc, t + 2);
                chk("rmw_write_addr", last_wr_addr, {v.addr[31:2], 2'b00});
            end
        end
        chk("mem_after_byte_store", mem[5], 32'hABCD0304);

        // Reset during RMW_RD of a half store abandons the access
        saved = mem[4];
        wr0 = n_wr;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01;
        req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h00007777;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gates_read", {31'h0, mem_read}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
        repeat (5) @(negedge clk);
        chk("abandon_no_write", n_wr, wr0);
        chk("abandon_mem_kept", mem[4], saved);

        // Back-to-back: word store accepted the cycle after a load's RESP
        issue(mk(0, 2'b10, 0, 32'h14, 0, 32'hABCD0304, 0, 2), t);
        issue(mk(1, 2'b10, 0, 32'h20, 32'hDEADBEEF, 0, 0, 2), t2);
        chk("b2b_accept_cycle", t2, t + 3);
        drain();
        chk("b2b_write_cycle", last_wr_cyc, t2 + 1);
        chk("b2b_mem", mem[8], 32'hDEADBEEF);
        issue(mk(0, 2'b10, 0, 32'h20, 0, 32'hDEADBEEF, 0, 2), t);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
